// File: rtl/matrix_inst_sequencer.sv
// Instruction sequencer: streams a program of matrix instructions from the BRAM
// to the dispatcher through a 2-entry prefetch buffer, and reports completion.
package matrix_inst_pkg;
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dst;
    logic [7:0] src_a;
    logic [7:0] src_b;
  } inst_t;
endpackage

module matrix_inst_sequencer
  import matrix_inst_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [INST_ADDR_WIDTH-1:0] inst_base,
  input  logic [INST_ADDR_WIDTH:0]   inst_count,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [INST_ADDR_WIDTH:0]   issued_cnt,
  output logic                       bram_en,
  output logic [INST_ADDR_WIDTH-1:0] bram_addr,
  input  logic [$bits(inst_t)-1:0]   bram_rdata,
  output inst_t                      m_inst,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [1:0]                 dbg_state
);
  // Handshake: an instruction transfers on any rising edge where m_valid and
  // m_ready are both high; m_inst is held stable while m_valid & !m_ready.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam int CW = INST_ADDR_WIDTH + 1;

  logic [1:0]                 state_q;
  logic [INST_ADDR_WIDTH-1:0] fetch_ptr_q;
  logic [INST_ADDR_WIDTH-1:0] addr_hold_q;
  logic [CW-1:0]              remaining_fetch_q;
  logic [CW-1:0]              remaining_issue_q;
  logic                       inflight_q;
  logic                       zero_done_q;
  inst_t                      tail_q;
  logic                       tail_valid_q;

  logic       pop;
  logic       push;
  logic       last_pop;
  logic       start_ok;
  logic       abort_ok;
  logic       fetch_ok;
  logic [2:0] credits_used;

  assign pop       = m_valid & m_ready;
  assign push      = inflight_q;
  assign last_pop  = pop && (remaining_issue_q == CW'(1));
  assign start_ok  = start && !abort && (state_q == S_IDLE);
  assign abort_ok  = abort && (state_q != S_IDLE);
  assign dbg_state = state_q;

  // A pop in this cycle frees a slot before the new read can land, which keeps
  // one instruction per cycle flowing while never exceeding two entries.
  assign credits_used = {2'b0, m_valid} + {2'b0, tail_valid_q} + {2'b0, inflight_q};
  assign fetch_ok     = credits_used < (3'd2 + {2'b0, pop});

  always_comb begin
    bram_en   = (state_q == S_RUN) && !abort && (remaining_fetch_q != '0) && fetch_ok;
    bram_addr = bram_en ? fetch_ptr_q : addr_hold_q;
    done      = zero_done_q | ((state_q == S_DRAIN) && m_ready && !abort);
    busy      = (state_q == S_RUN) | ((state_q == S_DRAIN) && !(m_ready && !abort));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      fetch_ptr_q       <= '0;
      addr_hold_q       <= '0;
      remaining_fetch_q <= '0;
      remaining_issue_q <= '0;
      issued_cnt        <= '0;
      zero_done_q       <= 1'b0;
    end else begin
      zero_done_q <= start_ok && (inst_count == '0);
      if (bram_en) begin
        fetch_ptr_q       <= fetch_ptr_q + 1'b1;
        addr_hold_q       <= fetch_ptr_q;
        remaining_fetch_q <= remaining_fetch_q - 1'b1;
      end
      if (pop) begin
        issued_cnt        <= issued_cnt + 1'b1;
        remaining_issue_q <= remaining_issue_q - 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_ok && (inst_count != '0)) begin
            state_q           <= S_RUN;
            fetch_ptr_q       <= inst_base;
            remaining_fetch_q <= inst_count;
            remaining_issue_q <= inst_count;
            issued_cnt        <= '0;
          end
        end
        S_RUN: begin
          if (abort) state_q <= S_IDLE;
          else if (last_pop) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (abort || m_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Prefetch buffer: m_inst/m_valid form the head register, tail_q the second slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_inst       <= '0;
      tail_q       <= '0;
      tail_valid_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else if (abort_ok) begin
      m_valid      <= 1'b0;
      tail_valid_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= bram_en;
      if (pop) begin
        if (tail_valid_q) begin
          m_inst <= tail_q;
          if (push) tail_q <= inst_t'(bram_rdata);
          else tail_valid_q <= 1'b0;
        end else if (push) begin
          m_inst <= inst_t'(bram_rdata);
        end else begin
          m_valid <= 1'b0;
        end
      end else if (push) begin
        if (!m_valid) begin
          m_inst  <= inst_t'(bram_rdata);
          m_valid <= 1'b1;
        end else begin
          tail_q       <= inst_t'(bram_rdata);
          tail_valid_q <= 1'b1;
        end
      end
    end
  end
endmodule
